// File: rtl/sccb_clk_gen_if.sv
// SCCB clock generator bus: run request in, serial clock, phase strobes and status out.
interface sccb_clk_gen_if;
    logic en_i;
    logic sccb_clk;
    logic ready_o;
    logic fall_stb;
    logic mid_low_stb;
    logic rise_stb;
    logic mid_high_stb;
    logic running_o;

    // Clock-generator side
    modport master (
        input  en_i,
        output sccb_clk, ready_o, fall_stb, mid_low_stb, rise_stb, mid_high_stb, running_o
    );

    // SCCB master / init sequencer side
    modport slave (
        output en_i,
        input  sccb_clk, ready_o, fall_stb, mid_low_stb, rise_stb, mid_high_stb, running_o
    );
endinterface

// File: rtl/sccb_clk_gen.sv
// SCCB serial clock generator with phase strobes, glitch-free run/stop and
// a power-up register-setup timer that gates the first transaction.
module sccb_clk_gen #(
    parameter int unsigned IN_FREQ   = 50_000_000,
    parameter int unsigned SCCB_FREQ = 100_000,
    parameter int unsigned T_SREG_MS = 300
) (
    input  logic           clk_i,
    input  logic           rst_i,
    sccb_clk_gen_if.master bus
);

    // Bits needed to hold val (at least 1)
    function automatic int unsigned calc_width(input longint unsigned val);
        int unsigned w;
        w = 1;
        while (w < 63 && (64'd1 << w) <= val) begin
            w = w + 1;
        end
        return w;
    endfunction

    localparam int unsigned HALF = IN_FREQ / (2 * SCCB_FREQ);
    localparam int unsigned QTR  = HALF / 2;

    localparam longint unsigned SREG_CYCLES = longint'(IN_FREQ / 1000) * longint'(T_SREG_MS);
    // Timer value on the edge that raises ready_o; 0 means the very first edge
    localparam longint unsigned SREG_LAST   = (SREG_CYCLES == 0) ? 0 : SREG_CYCLES - 1;

    localparam int unsigned KW = calc_width(longint'(HALF));
    localparam int unsigned SW = calc_width(SREG_LAST);

    localparam logic [KW-1:0] K_LAST    = KW'(HALF - 1);
    // Strobes are registered, so they are raised one count before k reaches QTR
    localparam logic [KW-1:0] K_PRE_MID = KW'(QTR - 1);
    localparam logic [SW-1:0] S_LAST    = SW'(SREG_LAST);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RUN_LOW  = 2'd1;
    localparam logic [1:0] RUN_HIGH = 2'd2;

    if (HALF < 4) begin : g_half_check
        $error("sccb_clk_gen: IN_FREQ/(2*SCCB_FREQ) must be at least 4");
    end

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [SW-1:0] sreg_q, sreg_d;
    logic          ready_q, ready_d;
    logic          sclk_q, sclk_d;
    logic          fall_q, fall_d;
    logic          midl_q, midl_d;
    logic          rise_q, rise_d;
    logic          midh_q, midh_d;
    logic          run_q, run_d;

    // Setup timer: count edges up to the last value and hold there; ready is sticky
    always_comb begin
        sreg_d  = sreg_q;
        ready_d = ready_q;
        if (sreg_q == S_LAST) begin
            ready_d = 1'b1;
        end else begin
            sreg_d = sreg_q + SW'(1);
        end
    end

    // Phase FSM: en_i is only looked at in IDLE and at the end of the high phase
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        sclk_d  = sclk_q;
        fall_d  = 1'b0;
        midl_d  = 1'b0;
        rise_d  = 1'b0;
        midh_d  = 1'b0;
        case (state_q)
            IDLE: begin
                k_d    = '0;
                sclk_d = 1'b1;
                if (ready_q && bus.en_i) begin
                    state_d = RUN_LOW;
                    sclk_d  = 1'b0;
                    fall_d  = 1'b1;
                end
            end
            RUN_LOW: begin
                if (k_q == K_LAST) begin
                    state_d = RUN_HIGH;
                    k_d     = '0;
                    sclk_d  = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    k_d    = k_q + KW'(1);
                    midl_d = (k_q == K_PRE_MID);
                end
            end
            RUN_HIGH: begin
                if (k_q == K_LAST) begin
                    k_d = '0;
                    if (bus.en_i) begin
                        state_d = RUN_LOW;
                        sclk_d  = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        sclk_d  = 1'b1;
                    end
                end else begin
                    k_d    = k_q + KW'(1);
                    midh_d = (k_q == K_PRE_MID);
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
                sclk_d  = 1'b1;
            end
        endcase
        run_d = (state_d != IDLE);
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            sreg_q  <= '0;
            ready_q <= 1'b0;
            sclk_q  <= 1'b1;
            fall_q  <= 1'b0;
            midl_q  <= 1'b0;
            rise_q  <= 1'b0;
            midh_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            sreg_q  <= sreg_d;
            ready_q <= ready_d;
            sclk_q  <= sclk_d;
            fall_q  <= fall_d;
            midl_q  <= midl_d;
            rise_q  <= rise_d;
            midh_q  <= midh_d;
            run_q   <= run_d;
        end
    end

    assign bus.sccb_clk     = sclk_q;
    assign bus.ready_o      = ready_q;
    assign bus.fall_stb     = fall_q;
    assign bus.mid_low_stb  = midl_q;
    assign bus.rise_stb     = rise_q;
    assign bus.mid_high_stb = midh_q;
    assign bus.running_o    = run_q;

endmodule

// File: tb/tb_sccb_clk_gen.sv
// Bench for sccb_clk_gen: strobe/ready events checked through a scoreboard queue,
// clock levels and status checked directly at the falling clock edge.
module tb_sccb_clk_gen;

    localparam int EV_RDY  = 0;
    localparam int EV_FALL = 1;
    localparam int EV_MIDL = 2;
    localparam int EV_RISE = 3;
    localparam int EV_MIDH = 4;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic clk;
    logic rst_i;
    int   ecount;
    int   checks;
    int   errors;
    logic ready_prev;
    exp_t sb_q[$];

    sccb_clk_gen_if bus ();
    sccb_clk_gen_if bus_z ();

    // HALF=5, SREG_CYCLES=1000
    sccb_clk_gen #(
        .IN_FREQ   (1_000_000),
        .SCCB_FREQ (100_000),
        .T_SREG_MS (1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // Truncated HALF (5) and no setup wait
    sccb_clk_gen #(
        .IN_FREQ   (1_000_000),
        .SCCB_FREQ (90_000),
        .T_SREG_MS (0)
    ) dut_z (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ecount = number of rising edges seen so far
    initial ecount = 0;
    always @(posedge clk) ecount <= ecount + 1;

    function automatic string kind_name(input int k);
        case (k)
            EV_RDY:  return "ready_rise";
            EV_FALL: return "fall_stb";
            EV_MIDL: return "mid_low_stb";
            EV_RISE: return "rise_stb";
            EV_MIDH: return "mid_high_stb";
            default: return "unknown";
        endcase
    endfunction

    task automatic push(input int kind, input int cyc);
        exp_t e;
        e.kind = kind;
        e.cyc  = cyc;
        sb_q.push_back(e);
    endtask

    // One full period starting with fall_stb at edge f
    task automatic push_period(input int f);
        push(EV_MIDL, f + 2);
        push(EV_RISE, f + 5);
        push(EV_MIDH, f + 7);
        push(EV_FALL, f + 10);
    endtask

    task automatic check_event(input int kind);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL event: got %s at edge %0d, expected nothing", kind_name(kind), ecount);
        end else begin
            e = sb_q.pop_front();
            if (e.kind != kind || e.cyc != ecount) begin
                errors++;
                $display("FAIL event: got %s at edge %0d, expected %s at edge %0d",
                         kind_name(kind), ecount, kind_name(e.kind), e.cyc);
            end
        end
    endtask

    // Monitor: every strobe or ready rising edge must match the queue head
    initial ready_prev = 1'b0;
    always @(negedge clk) begin
        int n;
        n = int'(bus.fall_stb) + int'(bus.mid_low_stb) + int'(bus.rise_stb)
            + int'(bus.mid_high_stb);
        if (n > 1) begin
            checks++;
            errors++;
            $display("FAIL exclusive: %0d strobes high at edge %0d, required at most 1", n, ecount);
        end
        if (bus.ready_o && !ready_prev) check_event(EV_RDY);
        if (bus.fall_stb)     check_event(EV_FALL);
        if (bus.mid_low_stb)  check_event(EV_MIDL);
        if (bus.rise_stb)     check_event(EV_RISE);
        if (bus.mid_high_stb) check_event(EV_MIDH);
        ready_prev <= bus.ready_o;
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b, required %b", name, ecount, act, exp);
        end
    endtask

    // Return at the falling edge after rising edge n
    task automatic goto(input int n);
        while (ecount < n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", ecount);
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_i = 1'b0;
        bus.en_i = 1'b0;
        bus_z.en_i = 1'b0;

        goto(3);
        chk("rst_sccb_clk", bus.sccb_clk, 1'b1);
        chk("rst_ready", bus.ready_o, 1'b0);
        chk("rst_running", bus.running_o, 1'b0);
        chk("rst_z_ready", bus_z.ready_o, 1'b0);

        // Release after edge 3: edge 4 is setup edge 1, ready at 1003, first fall at 1004
        push(EV_RDY, 1003);
        push(EV_FALL, 1004);
        for (int p = 0; p < 3; p++) push_period(1004 + 10 * p);
        // Stop period starting at 1034: no closing fall
        push(EV_MIDL, 1036);
        push(EV_RISE, 1039);
        push(EV_MIDH, 1041);
        rst_i = 1'b1;
        bus.en_i = 1'b1;
        bus_z.en_i = 1'b1;

        goto(4);
        chk("z_ready_first_edge", bus_z.ready_o, 1'b1);
        chk("ready_not_yet", bus.ready_o, 1'b0);
        goto(5);
        chk("z_fall", bus_z.sccb_clk, 1'b0);
        goto(9);
        chk("z_low_end", bus_z.sccb_clk, 1'b0);
        goto(10);
        chk("z_rise", bus_z.sccb_clk, 1'b1);
        goto(14);
        chk("z_high_end", bus_z.sccb_clk, 1'b1);
        goto(15);
        chk("z_refall", bus_z.sccb_clk, 1'b0);

        goto(1002);
        chk("gate_ready_999", bus.ready_o, 1'b0);
        chk("gate_clk_999", bus.sccb_clk, 1'b1);
        goto(1003);
        chk("gate_ready_1000", bus.ready_o, 1'b1);
        chk("gate_clk_1000", bus.sccb_clk, 1'b1);
        chk("gate_running_1000", bus.running_o, 1'b0);
        goto(1004);
        chk("first_fall_clk", bus.sccb_clk, 1'b0);
        chk("first_fall_running", bus.running_o, 1'b1);
        goto(1008);
        chk("low_k4", bus.sccb_clk, 1'b0);
        goto(1009);
        chk("high_k0", bus.sccb_clk, 1'b1);
        goto(1013);
        chk("high_k4", bus.sccb_clk, 1'b1);

        // Drop en at low-phase k=1 of the period starting at 1034
        goto(1035);
        bus.en_i = 1'b0;
        goto(1043);
        chk("stop_running_k4", bus.running_o, 1'b1);
        goto(1044);
        chk("stop_running", bus.running_o, 1'b0);
        chk("stop_clk", bus.sccb_clk, 1'b1);
        goto(1064);
        chk("idle_clk", bus.sccb_clk, 1'b1);
        chk("idle_running", bus.running_o, 1'b0);
        push(EV_FALL, 1065);
        bus.en_i = 1'b1;
        goto(1065);
        chk("restart_clk", bus.sccb_clk, 1'b0);
        chk("restart_running", bus.running_o, 1'b1);

        // Pulse-through: en low in RUN_LOW, high again at RUN_HIGH k=4
        push_period(1065);
        goto(1066);
        bus.en_i = 1'b0;
        goto(1074);
        bus.en_i = 1'b1;
        goto(1075);
        chk("pulse_clk", bus.sccb_clk, 1'b0);
        chk("pulse_running", bus.running_o, 1'b1);

        // Reset at RUN_LOW k=3 of the period starting at 1075
        push(EV_MIDL, 1077);
        goto(1078);
        rst_i = 1'b0;
        goto(1079);
        chk("midrst_clk", bus.sccb_clk, 1'b1);
        chk("midrst_ready", bus.ready_o, 1'b0);
        chk("midrst_running", bus.running_o, 1'b0);
        goto(1080);
        push(EV_RDY, 2080);
        push(EV_FALL, 2081);
        push(EV_MIDL, 2083);
        push(EV_RISE, 2086);
        push(EV_MIDH, 2088);
        rst_i = 1'b1;
        goto(2079);
        chk("regate_ready_999", bus.ready_o, 1'b0);
        chk("regate_clk_999", bus.sccb_clk, 1'b1);
        goto(2080);
        chk("regate_ready_1000", bus.ready_o, 1'b1);
        goto(2081);
        chk("regate_fall", bus.sccb_clk, 1'b0);
        goto(2082);
        bus.en_i = 1'b0;
        goto(2095);
        chk("final_clk", bus.sccb_clk, 1'b1);
        chk("final_running", bus.running_o, 1'b0);

        goto(2100);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d events never seen, required 0; next %s at edge %0d",
                     sb_q.size(), kind_name(sb_q[0].kind), sb_q[0].cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sccb_clk_gen.md
Name: sccb_clk_gen

Overview:
- Parametrised successor to the camera SCCB clock divider.
- Generates the SCCB serial clock from the system clock, plus single-cycle phase strobes (fall, data-change point, rise, sample point) for the SCCB master FSM.
- Adds a run/stop enable that never emits runt pulses, and a power-up register-setup timer (ready_o) that gates the first transaction.
- Sits between the system clock and the camera SCCB master / register-init sequencer.

Parameters:
- IN_FREQ, 50_000_000: clk_i frequency in Hz.
- SCCB_FREQ, 100_000: target SCCB clock frequency in Hz.
- T_SREG_MS, 300: power-up register setup time in ms; 0 disables the wait.
- Derived HALF = IN_FREQ/(2*SCCB_FREQ), truncating; default 250 cycles per half-period.
- Derived QTR = HALF/2, truncating; default 125.
- Derived SREG_CYCLES = (IN_FREQ/1000)*T_SREG_MS; default 15_000_000.
- Counter widths are sized from HALF and SREG_CYCLES with a constant clog2 function.
- Elaboration must fail if HALF < 4.

Ports:
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- en_i  in  1  request SCCB clock to run.
- sccb_clk  out  1  SCCB clock; idles high.
- ready_o  out  1  setup time elapsed; sticky until reset.
- fall_stb  out  1  1-cycle pulse, first cycle of the low phase.
- mid_low_stb  out  1  1-cycle pulse, centre of the low phase (SIO_D change point).
- rise_stb  out  1  1-cycle pulse, first cycle of the high phase.
- mid_high_stb  out  1  1-cycle pulse, centre of the high phase (SIO_D sample point).
- running_o  out  1  high while in RUN_LOW or RUN_HIGH.

Behaviour:
- All outputs are registered.
- Reset (rst_i=0 at a clk_i edge), regardless of state: sccb_clk=1, ready_o=0, running_o=0, all strobes=0, all counters=0, state=IDLE. Reset mid-phase truncates the phase immediately; sccb_clk returns high at the next edge.
- Setup timer:
  - Counts clk_i edges after reset release.
  - ready_o goes 1 on the SREG_CYCLES-th edge, or on the first edge if SREG_CYCLES=0, then holds at 1.
  - The timer saturates; it never wraps.
- Phase counter k: resets to 0 on phase entry, increments each cycle; k=0 is the first cycle sccb_clk shows the new level. Each phase lasts exactly HALF cycles, so period = 2*HALF.
- States:
  - IDLE: sccb_clk=1, no strobes, k held at 0. Go to RUN_LOW when ready_o=1 and en_i=1 (both sampled at the edge). On that edge: sccb_clk<=0, fall_stb<=1.
  - RUN_LOW: mid_low_stb=1 at k=QTR. At k=HALF-1 go to RUN_HIGH: sccb_clk<=1, rise_stb<=1.
  - RUN_HIGH: mid_high_stb=1 at k=QTR. At k=HALF-1, sample en_i:
    - en_i=1: go to RUN_LOW (sccb_clk<=0, fall_stb<=1).
    - en_i=0: go to IDLE with sccb_clk held at 1, no fall_stb.
- en_i is ignored except in IDLE and at RUN_HIGH k=HALF-1. Deasserting en_i mid-period always completes the full period (no runt pulse). Reasserting en_i before that decision point continues the clock without a gap.
- While ready_o=0, en_i has no effect.
- Strobes are mutually exclusive; at most one is high per cycle.
- Truncation of HALF is accepted; actual frequency = IN_FREQ/(2*HALF) >= SCCB_FREQ.

Test Plan (IN_FREQ=1_000_000, SCCB_FREQ=100_000 → HALF=5, QTR=2; T_SREG_MS=1 → SREG_CYCLES=1000 unless stated):
- Power-up gating: release reset, en_i=1 held → ready_o rises at edge 1000; sccb_clk=1 with no strobes through edge 1000; sccb_clk falls with fall_stb at edge 1001.
- Steady clock: en_i=1 for 3 periods → period 10 cycles, low 5/high 5. Per period, relative to fall_stb: mid_low_stb at +2, rise_stb at +5, mid_high_stb at +7, next fall_stb at +10; no other strobe pulses.
- Clean stop/restart: drop en_i at low-phase k=1 → rise_stb at +5 from fall, sccb_clk stays 1 indefinitely, running_o=0 at +10. Reassert en_i → fall_stb and sccb_clk=0 on the next edge.
- Pulse-through: en_i low during RUN_LOW but high again at RUN_HIGH k=4 → no gap; fall_stb exactly 10 cycles after the previous one.
- Reset mid-operation: assert rst_i at RUN_LOW k=3 → next edge sccb_clk=1, ready_o=0, strobes=0. After release, ready_o needs the full 1000 cycles again.
- Config edges: T_SREG_MS=0 → ready_o=1 after the first edge. IN_FREQ=1_000_000 with SCCB_FREQ=90_000 → HALF=5, period 10. SCCB_FREQ=200_000 → HALF=2, elaboration fails.
